// File: rtl/altera_up_ps2_rx_fifo_pkg.sv
// Shared constants for the PS/2 receive path: FSM state encoding and frame geometry.
package altera_up_ps2_rx_fifo_pkg;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_DATA   = 2'd1;
  localparam logic [1:0] STATE_PARITY = 2'd2;
  localparam logic [1:0] STATE_STOP   = 2'd3;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/altera_up_ps2_rx_buffer.sv
// Show-ahead synchronous FIFO holding received PS/2 bytes; a simultaneous push and
// pop always both succeed, even when the FIFO is full.
module altera_up_ps2_rx_buffer #(
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic [7:0]               write_data,
  input  logic                     read_en,
  output logic [7:0]               read_data,
  output logic                     empty,
  output logic [FIFO_ADDR_WIDTH:0] count,
  output logic                     overflow_event
);

  localparam logic [FIFO_ADDR_WIDTH:0] FULL_COUNT = FIFO_DEPTH[FIFO_ADDR_WIDTH:0];

  logic [7:0]                 mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic                       full;
  logic                       do_read;
  logic                       do_write;

  assign empty          = (count == '0);
  assign full           = (count == FULL_COUNT);
  assign do_read        = read_en & ~empty;
  assign do_write       = write_en & (~full | do_read);
  assign overflow_event = write_en & full & ~do_read;
  assign read_data      = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= write_data;
  end

  // Pointers are exactly FIFO_ADDR_WIDTH bits wide, so they wrap at FIFO_DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !do_read)      count <= count + 1'b1;
      else if (!do_write && do_read) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/altera_up_ps2_rx_fifo.sv
// PS/2 receiver: synchronises the raw lines, deframes bytes and queues them in a FIFO.
// Define ALTERA_UP_PS2_PARITY_CHECK_EN to reject frames that fail the odd-parity check.
module altera_up_ps2_rx_fifo
  import altera_up_ps2_rx_fifo_pkg::*;
#(
  parameter int CLOCK_CYCLES_FOR_TIMEOUT = 100000,
  parameter int DATA_WIDTH_FOR_TIMEOUT   = 17,
  parameter int FIFO_DEPTH               = 16,
  parameter int FIFO_ADDR_WIDTH          = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PS2_CLK,
  input  logic                     PS2_DAT,
  input  logic                     read_en,
  input  logic                     clear_errors,
  output logic [7:0]               received_data,
  output logic                     data_available,
  output logic [FIFO_ADDR_WIDTH:0] fifo_count,
  output logic                     overflow,
  output logic                     frame_error
);

  localparam logic [DATA_WIDTH_FOR_TIMEOUT-1:0] TIMEOUT_LAST =
    DATA_WIDTH_FOR_TIMEOUT'(CLOCK_CYCLES_FOR_TIMEOUT - 1);
  localparam logic [2:0] LAST_DATA_BIT = 3'(PS2_DATA_BITS - 1);

  logic                              ps2_clk_meta, ps2_clk_sync, ps2_clk_last;
  logic                              ps2_dat_meta, ps2_dat_sync;
  logic                              falling_edge;
  logic [1:0]                        state;
  logic [2:0]                        bit_count;
  logic [7:0]                        shift_reg;
  logic [DATA_WIDTH_FOR_TIMEOUT-1:0] timeout_count;
  logic                              push;
  logic                              parity_ok;
  logic                              fifo_empty;
  logic                              overflow_event;

`ifdef ALTERA_UP_PS2_PARITY_CHECK_EN
  logic parity_bit;
  assign parity_ok = ^{shift_reg, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // Lines idle high, so the synchronisers load 1 to avoid a false edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_clk_meta <= 1'b1;
      ps2_clk_sync <= 1'b1;
      ps2_clk_last <= 1'b1;
      ps2_dat_meta <= 1'b1;
      ps2_dat_sync <= 1'b1;
    end else begin
      ps2_clk_meta <= PS2_CLK;
      ps2_clk_sync <= ps2_clk_meta;
      ps2_clk_last <= ps2_clk_sync;
      ps2_dat_meta <= PS2_DAT;
      ps2_dat_sync <= ps2_dat_meta;
    end
  end

  assign falling_edge = ps2_clk_last & ~ps2_clk_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= STATE_IDLE;
      bit_count     <= '0;
      shift_reg     <= '0;
      timeout_count <= '0;
      push          <= 1'b0;
      frame_error   <= 1'b0;
`ifdef ALTERA_UP_PS2_PARITY_CHECK_EN
      parity_bit    <= 1'b0;
`endif
    end else begin
      push        <= 1'b0;
      frame_error <= 1'b0;
      if (state != STATE_IDLE && !falling_edge && timeout_count == TIMEOUT_LAST) begin
        state         <= STATE_IDLE;
        timeout_count <= '0;
        frame_error   <= 1'b1;
      end else begin
        if (state == STATE_IDLE || falling_edge) timeout_count <= '0;
        else                                      timeout_count <= timeout_count + 1'b1;
        if (falling_edge) begin
          case (state)
            STATE_IDLE: begin
              if (!ps2_dat_sync) begin
                state     <= STATE_DATA;
                bit_count <= '0;
              end
            end
            STATE_DATA: begin
              shift_reg <= {ps2_dat_sync, shift_reg[7:1]};
              if (bit_count == LAST_DATA_BIT) state <= STATE_PARITY;
              else                            bit_count <= bit_count + 1'b1;
            end
            STATE_PARITY: begin
`ifdef ALTERA_UP_PS2_PARITY_CHECK_EN
              parity_bit <= ps2_dat_sync;
`endif
              state <= STATE_STOP;
            end
            default: begin
              state <= STATE_IDLE;
              if (ps2_dat_sync && parity_ok) push        <= 1'b1;
              else                           frame_error <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  // A fresh overflow in the same cycle as clear_errors keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) overflow <= 1'b0;
    else       overflow <= overflow_event | (overflow & ~clear_errors);
  end

  altera_up_ps2_rx_buffer #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_buffer (
    .clk            (clk),
    .reset          (reset),
    .write_en       (push),
    .write_data     (shift_reg),
    .read_en        (read_en),
    .read_data      (received_data),
    .empty          (fifo_empty),
    .count          (fifo_count),
    .overflow_event (overflow_event)
  );

  assign data_available = ~fifo_empty;

endmodule

// File: tb/tb_altera_up_ps2_rx_fifo.sv
// Directed bench for altera_up_ps2_rx_fifo with hand-computed expected values.
// Parity-dependent checks follow ALTERA_UP_PS2_PARITY_CHECK_EN.
module tb_altera_up_ps2_rx_fifo;
  import altera_up_ps2_rx_fifo_pkg::*;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic       read_en = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] received_data;
  logic       data_available;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       frame_error;

  int vectors = 0;
  int miscompares = 0;
  int fe_count = 0;
  int fe_base;

  altera_up_ps2_rx_fifo #(
    .CLOCK_CYCLES_FOR_TIMEOUT (1000),
    .DATA_WIDTH_FOR_TIMEOUT   (17),
    .FIFO_DEPTH               (16),
    .FIFO_ADDR_WIDTH          (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .PS2_CLK        (PS2_CLK),
    .PS2_DAT        (PS2_DAT),
    .read_en        (read_en),
    .clear_errors   (clear_errors),
    .received_data  (received_data),
    .data_available (data_available),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .frame_error    (frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_error === 1'b1) fe_count++;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives the first 'edges' bits of a frame; pop_on_push raises read_en exactly on the push cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic parity, input logic stop,
                               input int edges, input logic pop_on_push);
    logic [10:0] frame;
    frame = {stop, parity, data, 1'b0};
    for (int i = 0; i < edges; i++) begin
      PS2_DAT = frame[i];
      waitCycles(HALF);
      PS2_CLK = 1'b0;
      if (pop_on_push && i == PS2_FRAME_BITS - 1) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        waitCycles(HALF - 4);
      end else begin
        waitCycles(HALF);
      end
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    waitCycles(HALF);
  endtask

  task automatic popByte();
    @(negedge clk);
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
  endtask

  initial begin
    waitCycles(3);
    checkOutput("reset received_data", received_data, 8'h00);
    checkOutput("reset data_available", data_available, 0);
    checkOutput("reset fifo_count", fifo_count, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset frame_error", frame_error, 0);
    reset = 1'b0;
    waitCycles(2);

    // 0x1C has three ones, so parity 0 gives odd overall parity.
    applyStimulus(8'h1C, 1'b0, 1'b1, PS2_FRAME_BITS, 1'b0);
    checkOutput("1C data_available", data_available, 1);
    checkOutput("1C received_data", received_data, 8'h1C);
    checkOutput("1C fifo_count", fifo_count, 1);
    checkOutput("1C no frame_error", fe_count, 0);
    popByte();
    checkOutput("1C popped count", fifo_count, 0);
    checkOutput("1C popped avail", data_available, 0);

    fe_base = fe_count;
    applyStimulus(8'h1C, 1'b1, 1'b1, PS2_FRAME_BITS, 1'b0);
`ifdef ALTERA_UP_PS2_PARITY_CHECK_EN
    checkOutput("bad parity frame_error", fe_count - fe_base, 1);
    checkOutput("bad parity count", fifo_count, 0);
`else
    checkOutput("ignored parity frame_error", fe_count - fe_base, 0);
    checkOutput("ignored parity count", fifo_count, 1);
    checkOutput("ignored parity data", received_data, 8'h1C);
    popByte();
`endif

    fe_base = fe_count;
    applyStimulus(8'h55, 1'b1, 1'b0, PS2_FRAME_BITS, 1'b0);
    checkOutput("bad stop frame_error", fe_count - fe_base, 1);
    checkOutput("bad stop count", fifo_count, 0);

    popByte();
    checkOutput("empty pop count", fifo_count, 0);

    for (int i = 0; i < 17; i++) begin
      logic [7:0] b;
      b = 8'h10 + 8'(i);
      applyStimulus(b, ~(^b), 1'b1, PS2_FRAME_BITS, 1'b0);
    end
    checkOutput("overflow count", fifo_count, 16);
    checkOutput("overflow flag", overflow, 1);
    checkOutput("overflow head", received_data, 8'h10);
    @(negedge clk);
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    checkOutput("cleared overflow", overflow, 0);
    checkOutput("cleared count", fifo_count, 16);

    applyStimulus(8'h30, 1'b1, 1'b1, PS2_FRAME_BITS, 1'b1);
    checkOutput("full push+pop count", fifo_count, 16);
    checkOutput("full push+pop overflow", overflow, 0);
    checkOutput("full push+pop head", received_data, 8'h11);
    for (int i = 0; i < 15; i++) begin
      checkOutput("drain head", received_data, 8'h11 + i);
      popByte();
    end
    checkOutput("wrapped tail byte", received_data, 8'h30);
    popByte();
    checkOutput("drained count", fifo_count, 0);

    fe_base = fe_count;
    applyStimulus(8'h0F, 1'b1, 1'b1, 5, 1'b0);
    waitCycles(900);
    checkOutput("no early timeout", fe_count - fe_base, 0);
    for (int i = 0; i < 300 && fe_count == fe_base; i++) @(negedge clk);
    waitCycles(20);
    checkOutput("timeout frame_error", fe_count - fe_base, 1);
    applyStimulus(8'hF0, 1'b1, 1'b1, PS2_FRAME_BITS, 1'b0);
    checkOutput("after timeout data", received_data, 8'hF0);
    checkOutput("after timeout count", fifo_count, 1);
    popByte();

    applyStimulus(8'h3C, 1'b1, 1'b1, PS2_FRAME_BITS, 1'b0);
    applyStimulus(8'hAA, 1'b1, 1'b1, 6, 1'b0);
    fe_base = fe_count;
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(2);
    checkOutput("midframe reset count", fifo_count, 0);
    checkOutput("midframe reset avail", data_available, 0);
    checkOutput("midframe reset data", received_data, 8'h00);
    checkOutput("midframe reset overflow", overflow, 0);
    checkOutput("midframe reset no frame_error", fe_count - fe_base, 0);
    applyStimulus(8'hAA, 1'b1, 1'b1, PS2_FRAME_BITS, 1'b0);
    checkOutput("post reset data", received_data, 8'hAA);
    checkOutput("post reset count", fifo_count, 1);
    checkOutput("post reset no frame_error", fe_count - fe_base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/altera_up_ps2_rx_fifo.md
ALTERA_UP_PS2_RX_FIFO -- requirements
Module: altera_up_ps2_rx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_CYCLES_FOR_TIMEOUT, default 100000, meaning the inter-edge timeout in clk cycles (2 ms at 50 MHz).
REQ-002 SHALL have parameter DATA_WIDTH_FOR_TIMEOUT, default 17, meaning the timeout counter width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning the number of stored bytes (power of two, 2..256).
REQ-004 SHALL have parameter FIFO_ADDR_WIDTH, default 4, equal to log2(FIFO_DEPTH).
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have ports PS2_CLK and PS2_DAT, input, 1 each, the raw asynchronous PS/2 lines.
REQ-008 SHALL have port read_en, input, 1, pop the head byte.
REQ-009 SHALL have port clear_errors, input, 1, clear sticky error state.
REQ-010 SHALL have port received_data, output, 8, head byte (show-ahead).
REQ-011 SHALL have port data_available, output, 1, FIFO not empty.
REQ-012 SHALL have port fifo_count, output, FIFO_ADDR_WIDTH+1, bytes held.
REQ-013 SHALL have port overflow, output, 1, sticky: a byte was dropped because the FIFO was full.
REQ-014 SHALL have port frame_error, output, 1, one-cycle pulse on a rejected frame.

Function
REQ-015 SHALL pass PS2_CLK and PS2_DAT through two flops each; a falling edge is synced clock 1->0 between consecutive cycles.
REQ-016 SHALL use FSM states IDLE, DATA, PARITY, STOP; bits are sampled only on a detected falling edge.
REQ-017 IDLE SHALL go to DATA on a falling edge with data 0 (start bit); a falling edge with data 1 is ignored.
REQ-018 DATA SHALL shift in 8 bits LSB-first, then go to PARITY; PARITY captures one bit, then goes to STOP.
REQ-019 STOP SHALL, on a falling edge, return to IDLE; stop bit 1 with a valid frame pushes the byte, and stop bit 0 pulses frame_error with no push.
REQ-020 The push SHALL occur on the cycle after the stop-bit edge is detected; data_available rises the following cycle.
REQ-021 In any non-IDLE state, CLOCK_CYCLES_FOR_TIMEOUT cycles without a falling edge SHALL force IDLE, discard the partial byte, and pulse frame_error; the counter reloads on every edge.
REQ-022 read_en with the FIFO empty SHALL be ignored; fifo_count never underflows.
REQ-023 A push with the FIFO full and no read_en SHALL drop the new byte and set overflow; existing contents are unchanged.
REQ-024 A push and read_en in the same cycle SHALL both succeed at any fill level, including full, with fifo_count unchanged and no overflow.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 clear_errors SHALL clear overflow; if a new overflow occurs in the same cycle, set wins.

Reset
REQ-027 On reset the FSM SHALL enter IDLE and all outputs SHALL go to 0: received_data 8'h00, data_available 0, fifo_count 0, overflow 0, frame_error 0.
REQ-028 On reset, synchroniser flops SHALL load 1 and the FIFO SHALL empty; a frame in progress is discarded without a frame_error pulse.

Configuration
REQ-029 With macro ALTERA_UP_PS2_PARITY_CHECK_EN defined, a frame SHALL be rejected (no push, frame_error pulse) unless data plus parity bit has odd parity.
REQ-030 Without the macro, the parity bit SHALL be sampled and ignored.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2-bit localparams) and the PS/2 frame constants (8 data bits, 11-bit frame).
REQ-032 Storage SHALL be one sub-module, altera_up_ps2_rx_buffer: a show-ahead synchronous FIFO parameterised by FIFO_DEPTH and FIFO_ADDR_WIDTH.

Verification
REQ-033 Send frame 0x1C with parity 0 and stop 1 -> data_available=1, received_data=0x1C, fifo_count=1; read_en -> fifo_count=0.
REQ-034 With ALTERA_UP_PS2_PARITY_CHECK_EN, send 0x1C with parity 1 -> frame_error pulses once, fifo_count stays 0; without the macro -> 0x1C is stored.
REQ-035 Send 17 frames with FIFO_DEPTH=16 and no reads -> fifo_count=16, overflow=1, head=first byte; clear_errors -> overflow=0.
REQ-036 FIFO full, push coinciding with read_en -> fifo_count=16, overflow=0, next head is the second byte.
REQ-037 Stop PS2_CLK after 4 data bits, CLOCK_CYCLES_FOR_TIMEOUT=1000 -> frame_error pulses after 1000 idle cycles; a following frame 0xF0 is received correctly.
REQ-038 Assert reset mid-frame -> all outputs 0, no frame_error; the next full frame 0xAA is received.
